ocp_arbiter: RTL and testbench
==============================

# ocp_arbiter

Parametrised N-master to 1-slave OCP request arbiter with in-order response routing. Sits between several OCP masters (cores, DMA) and a single shared OCP slave port (memory or peripheral bus). Grants masters round-robin, forwards the granted request to the slave, and returns each slave response to the master that issued the matching request.

## Interface
Parameters:
- N_MASTERS, 4 — number of master ports, ≥ 2
- ADDR_WIDTH, 32 — address width
- DATA_WIDTH, 32 — data width
- MAX_OUTSTANDING, 4 — response-expecting requests in flight, ≥ 1

Ports (clock is `clk`; reset is `reset`, synchronous, active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- m_MCmd  in  N_MASTERS×Bus::Ocp_cmd  per-master command
- m_MAddr  in  N_MASTERS×ADDR_WIDTH  per-master address
- m_MData  in  N_MASTERS×DATA_WIDTH  per-master write data
- m_SCmdAccept  out  N_MASTERS  per-master accept
- m_SResp  out  N_MASTERS×Bus::Ocp_resp  per-master response
- m_SData  out  N_MASTERS×DATA_WIDTH  per-master read data
- s_MCmd  out  Bus::Ocp_cmd  command to slave
- s_MAddr  out  ADDR_WIDTH  address to slave
- s_MData  out  DATA_WIDTH  write data to slave
- s_SCmdAccept  in  1  slave accept
- s_SResp  in  Bus::Ocp_resp  slave response
- s_SData  in  DATA_WIDTH  slave read data

## Operation
- Requester: master i with m_MCmd[i] ≠ IDLE.
- Response-expecting commands: RD, RDEX, RDL, WRNP, WRC. WR and BCST are posted (no response).
- States: ARB, HOLD. In ARB, pick the first requester at or after rr_ptr (wrap-around). Drive its command onto s_*. If s_SCmdAccept=0, go to HOLD with the grant latched. HOLD keeps that grant until accept, ignoring all other masters, so OCP command stability is preserved. On accept, return to ARB and set rr_ptr = granted+1 mod N_MASTERS.
- Accept of a response-expecting command pushes the granted index (width Bus::clog2(N_MASTERS), min 1) into the tag FIFO.
- FIFO full: a response-expecting request is not forwarded (s_MCmd=IDLE, m_SCmdAccept=0). A posted request from that master or any other is still eligible. Masters blocked by a full FIFO are skipped in arbitration.
- s_SResp ≠ NULL: route s_SResp/s_SData to the master at the FIFO head, then pop. All other m_SResp are NULL. Slave responses arrive strictly in order and are always consumed (no MRespAccept).
- Push and pop in the same cycle when full: the push is allowed, and occupancy is unchanged.
- Response with FIFO empty: dropped; no master sees it.
- No requesters: s_MCmd=IDLE, state ARB.

## Timing
- Request path is combinational: master to slave in 0 cycles, and m_SCmdAccept[g] = s_SCmdAccept in the same cycle.
- Response path is combinational from s_SResp through the FIFO head, 0 cycles.
- Grant, rr_ptr, state and FIFO pointers are registered on posedge clk.
- Reset: state=ARB, rr_ptr=0, FIFO empty, lock cleared. All outputs settle combinationally: s_MCmd=IDLE, m_SCmdAccept=0, m_SResp=NULL, data outputs 0.
- Reset mid-transfer discards all outstanding tags. Responses after reset are dropped.

## Configuration
- OCP_ARB_LOCK_EN defined: an accepted RDL from master i sets lock. While locked, only master i is eligible. Lock clears when master i has a WR or WRC accepted.
- Undefined: RDL is arbitrated exactly like RD, and no lock state exists.

## Structure
- Package Bus gains function cmd_expects_resp(Ocp_cmd) and the state typedef Arb_state {ARB, HOLD}. Sizing uses Bus::clog2.
- One sub-module: ocp_tag_fifo, a synchronous FIFO parametrised by WIDTH and DEPTH, with push/pop/full/empty.

## Test plan
- Masters 0 and 2 assert RD at the same time, slave accepts every cycle -> grants go 0, 2, 0, 2. DVA responses reach m_SResp[0], then m_SResp[2].
- Master 1 WR, s_SCmdAccept held 0 for 3 cycles while master 3 requests -> s_* stays on master 1 for 4 cycles, then master 3 is granted.
- MAX_OUTSTANDING=2: 3 RDs accepted back-to-back with no responses -> the third is stalled. A WR from another master still passes. The first response unblocks the third RD.
- FIFO full, and a response plus a new RD accept in the same cycle -> occupancy stays 2 and the response goes to the correct master.
- reset asserted with 2 reads outstanding -> all outputs at reset values next cycle. A later stray DVA is not routed to any master.
- With OCP_ARB_LOCK_EN: master 0 RDL, then master 1 RD, then master 0 WRC -> master 1 is granted only after the WRC is accepted.

Source files
------------

// File: rtl/ocp_arbiter_pkg.sv
// Shared OCP types for the arbiter: command/response encodings, arbiter state
// and sizing helpers.
package Bus;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        RDEX = 3'd3,
        RDL  = 3'd4,
        WRNP = 3'd5,
        WRC  = 3'd6,
        BCST = 3'd7
    } Ocp_cmd;

    typedef enum logic [1:0] {
        NULL = 2'd0,
        DVA  = 2'd1,
        FAIL = 2'd2,
        ERR  = 2'd3
    } Ocp_resp;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } Arb_state;

    // Bits needed to index n items; never less than 1 so a 1-entry index still has a wire.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic logic cmd_expects_resp(input Ocp_cmd c);
        case (c)
            RD, RDEX, RDL, WRNP, WRC: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ocp_arbiter_tag.sv
// Synchronous tag FIFO: remembers which master owns each in-flight response.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ocp_tag_fifo
    import Bus::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ocp_arbiter.sv
// N-master to 1-slave OCP request arbiter, round-robin with in-order response
// routing. Define OCP_ARB_LOCK_EN to make RDL lock the bus until WR/WRC.
module ocp_arbiter
    import Bus::*;
#(
    parameter int N_MASTERS       = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  Ocp_cmd                m_MCmd       [N_MASTERS],
    input  logic [ADDR_WIDTH-1:0] m_MAddr      [N_MASTERS],
    input  logic [DATA_WIDTH-1:0] m_MData      [N_MASTERS],
    output logic [N_MASTERS-1:0]  m_SCmdAccept,
    output Ocp_resp               m_SResp      [N_MASTERS],
    output logic [DATA_WIDTH-1:0] m_SData      [N_MASTERS],
    output Ocp_cmd                s_MCmd,
    output logic [ADDR_WIDTH-1:0] s_MAddr,
    output logic [DATA_WIDTH-1:0] s_MData,
    input  logic                  s_SCmdAccept,
    input  Ocp_resp               s_SResp,
    input  logic [DATA_WIDTH-1:0] s_SData,
    output Arb_state              o_dbg_state
);

    localparam int TAG_W = clog2(N_MASTERS);

    Arb_state             r_state;
    Arb_state             w_state_nxt;
    logic [TAG_W-1:0]     r_rr_ptr;
    logic [TAG_W-1:0]     r_grant;
    logic [TAG_W-1:0]     w_arb_grant;
    logic [TAG_W-1:0]     w_grant;
    logic [TAG_W-1:0]     w_head;
    logic                 w_arb_found;
    logic                 w_valid;
    logic                 w_fire;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_resp_room;
    logic [N_MASTERS-1:0] w_lock_mask;
    logic [N_MASTERS-1:0] w_eligible;
    Ocp_cmd               w_cmd;

    function automatic logic [TAG_W-1:0] rr_index(input logic [TAG_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_MASTERS) s = s - N_MASTERS;
        return TAG_W'(s);
    endfunction

    // A response arriving this cycle frees a slot, so a full FIFO can still take a new tag.
    assign w_pop       = !reset && (s_SResp != NULL) && !w_fifo_empty;
    assign w_resp_room = !w_fifo_full || w_pop;

`ifdef OCP_ARB_LOCK_EN
    logic             r_locked;
    logic [TAG_W-1:0] r_lock_owner;

    always_comb begin
        w_lock_mask = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_lock_mask[i] = !r_locked || (r_lock_owner == TAG_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_locked     <= 1'b0;
            r_lock_owner <= '0;
        end else if (w_fire) begin
            if (w_cmd == RDL) begin
                r_locked     <= 1'b1;
                r_lock_owner <= w_grant;
            end else if (r_locked && (w_grant == r_lock_owner) && ((w_cmd == WR) || (w_cmd == WRC))) begin
                r_locked <= 1'b0;
            end
        end
    end
`else
    assign w_lock_mask = '1;
`endif

    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_eligible[i] = (m_MCmd[i] != IDLE) && w_lock_mask[i] &&
                            (w_resp_room || !cmd_expects_resp(m_MCmd[i]));
        end
    end

    // Scan downward so the nearest eligible master after rr_ptr wins.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_grant = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (w_eligible[rr_index(r_rr_ptr, k)]) begin
                w_arb_found = 1'b1;
                w_arb_grant = rr_index(r_rr_ptr, k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = r_grant;
        w_valid     = 1'b0;
        case (r_state)
            ARB: begin
                w_grant = w_arb_grant;
                w_valid = w_arb_found;
                if (w_valid && !s_SCmdAccept) w_state_nxt = HOLD;
            end
            HOLD: begin
                w_valid = (m_MCmd[r_grant] != IDLE) &&
                          (w_resp_room || !cmd_expects_resp(m_MCmd[r_grant]));
                if (!w_valid || s_SCmdAccept) w_state_nxt = ARB;
            end
            default: w_state_nxt = ARB;
        endcase
        if (reset) w_valid = 1'b0;
    end

    assign w_cmd  = m_MCmd[w_grant];
    assign w_fire = w_valid && s_SCmdAccept;
    assign w_push = w_fire && cmd_expects_resp(w_cmd);

    always_comb begin
        s_MCmd       = IDLE;
        s_MAddr      = '0;
        s_MData      = '0;
        m_SCmdAccept = '0;
        if (w_valid) begin
            s_MCmd                = w_cmd;
            s_MAddr               = m_MAddr[w_grant];
            s_MData               = m_MData[w_grant];
            m_SCmdAccept[w_grant] = s_SCmdAccept;
        end
    end

    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            m_SResp[i] = NULL;
            m_SData[i] = '0;
        end
        if (w_pop) begin
            m_SResp[w_head] = s_SResp;
            m_SData[w_head] = s_SData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ARB;
            r_rr_ptr <= '0;
            r_grant  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB) r_grant  <= w_arb_grant;
            if (w_fire)         r_rr_ptr <= rr_index(w_grant, 1);
        end
    end

    assign o_dbg_state = r_state;

    ocp_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_grant),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_ocp_arbiter.sv
// Directed bench for ocp_arbiter (4 masters, 2 outstanding); the lock scenario
// follows OCP_ARB_LOCK_EN.
module tb_ocp_arbiter;
  import Bus::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  Ocp_cmd        m_cmd   [N];
  logic [AW-1:0] m_addr  [N];
  logic [DW-1:0] m_data  [N];
  logic [N-1:0]  m_acc;
  Ocp_resp       m_resp  [N];
  logic [DW-1:0] m_sdata [N];
  Ocp_cmd        s_cmd;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  logic          s_acc;
  Ocp_resp       s_resp;
  logic [DW-1:0] s_sdata;
  Arb_state      dbg;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [1:0] exp_q[$];

  ocp_arbiter #(
    .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset),
    .m_MCmd(m_cmd), .m_MAddr(m_addr), .m_MData(m_data),
    .m_SCmdAccept(m_acc), .m_SResp(m_resp), .m_SData(m_sdata),
    .s_MCmd(s_cmd), .s_MAddr(s_addr), .s_MData(s_data),
    .s_SCmdAccept(s_acc), .s_SResp(s_resp), .s_SData(s_sdata),
    .o_dbg_state(dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic drive(input int i, input Ocp_cmd c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_cmd[i]  = c;
    m_addr[i] = a;
    m_data[i] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) drive(i, IDLE, '0, '0);
  endtask

  // scoreboard / checkers
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd"}, s_cmd, IDLE);
    check({tag, "_addr"}, s_addr, '0);
    check({tag, "_data"}, s_data, '0);
    check({tag, "_acc"}, m_acc, '0);
  endtask

  // Expects master m on the slave port; pushes its tag when a response is owed.
  task automatic check_grant(input string tag, input int m, input logic resp_exp);
    check({tag, "_cmd"}, s_cmd, m_cmd[m]);
    check({tag, "_addr"}, s_addr, m_addr[m]);
    check({tag, "_data"}, s_data, m_data[m]);
    check({tag, "_acc"}, m_acc, s_acc ? (4'b0001 << m) : 4'b0000);
    if (s_acc && resp_exp) exp_q.push_back(2'(m));
  endtask

  // With an empty queue no master may see the response.
  task automatic check_resp(input string tag, input logic [DW-1:0] d);
    int exp_m = -1;
    if (exp_q.size() > 0) exp_m = int'(exp_q.pop_front());
    for (int j = 0; j < N; j++) begin
      check($sformatf("%s_resp%0d", tag, j), m_resp[j], (j == exp_m) ? DVA : NULL);
      check($sformatf("%s_sdata%0d", tag, j), m_sdata[j], (j == exp_m) ? d : 32'h0);
    end
  endtask

  initial begin
    idle_all();
    s_acc   = 1'b0;
    s_resp  = NULL;
    s_sdata = '0;

    // reset holds every output quiet even with live traffic
    @(negedge clk);
    drive(1, RD, 32'h1000, '0);
    s_acc = 1'b1; s_resp = DVA; s_sdata = 32'hDEAD;
    #1;
    check_idle("rst");
    check_resp("rst", '0);
    check("rst_state", dbg, ARB);

    // round robin 0,2,0,2 with responses back in order
    @(negedge clk);
    reset = 1'b0; s_resp = NULL; s_sdata = '0; idle_all();
    drive(0, RD, 32'h0000, '0); drive(2, RD, 32'h2000, '0);
    #1; check_resp("a1", '0); check_grant("a1", 0, 1'b1);
    @(negedge clk);
    drive(0, RD, 32'h0004, '0);
    #1; check_grant("a2", 2, 1'b1);
    @(negedge clk);
    s_resp = DVA; s_sdata = 32'hD000_0000;
    #1; check_resp("a3", 32'hD000_0000); check_grant("a3", 0, 1'b1);
    @(negedge clk);
    drive(2, RD, 32'h2004, '0); s_sdata = 32'hD000_0001;
    #1; check_resp("a4", 32'hD000_0001); check_grant("a4", 2, 1'b1);

    // FIFO stays full after push+pop: reads stall, a posted write passes
    @(negedge clk);
    s_resp = NULL;
    #1; check_idle("a5_full");
    @(negedge clk);
    drive(1, WR, 32'h1000, 32'h55);
    #1; check_grant("a6_post", 1, 1'b0);
    @(negedge clk);
    drive(1, IDLE, '0, '0); s_resp = DVA; s_sdata = 32'hD000_0002;
    #1; check_resp("a7", 32'hD000_0002); check_grant("a7", 2, 1'b1);
    @(negedge clk);
    idle_all(); s_sdata = 32'hD000_0003;
    #1; check_resp("a8", 32'hD000_0003); check_idle("a8");
    @(negedge clk);
    s_sdata = 32'hD000_0004;
    #1; check_resp("a9", 32'hD000_0004);
    @(negedge clk);
    s_sdata = 32'hD000_0005;
    #1; check_resp("a10_stray", 32'hD000_0005);

    // HOLD: master 1 stays on the slave until accepted, then master 3
    @(negedge clk);
    s_resp = NULL; s_acc = 1'b0;
    drive(1, WR, 32'h1008, 32'hAA);
    #1; check_grant("b1", 1, 1'b0); check("b1_state", dbg, ARB);
    @(negedge clk);
    drive(3, RD, 32'h3000, '0);
    #1; check_grant("b2", 1, 1'b0); check("b2_state", dbg, HOLD);
    @(negedge clk);
    #1; check_grant("b3", 1, 1'b0); check("b3_state", dbg, HOLD);
    @(negedge clk);
    s_acc = 1'b1;
    #1; check_grant("b4", 1, 1'b0);
    @(negedge clk);
    drive(1, IDLE, '0, '0);
    #1; check_grant("b5", 3, 1'b1); check("b5_state", dbg, ARB);
    @(negedge clk);
    idle_all(); s_resp = DVA; s_sdata = 32'hD000_0006;
    #1; check_resp("b6", 32'hD000_0006);

    // RDL handling
    @(negedge clk);
    s_resp = NULL;
    drive(0, RDL, 32'h0010, '0);
    #1; check_grant("c1", 0, 1'b1);
`ifdef OCP_ARB_LOCK_EN
    @(negedge clk);
    drive(0, IDLE, '0, '0); drive(1, RD, 32'h1010, '0);
    #1; check_idle("c2_locked");
    @(negedge clk);
    drive(0, WRC, 32'h0014, 32'h77);
    #1; check_grant("c3", 0, 1'b1);
    @(negedge clk);
    drive(0, IDLE, '0, '0); s_resp = DVA; s_sdata = 32'hD000_0007;
    #1; check_resp("c4", 32'hD000_0007); check_grant("c4", 1, 1'b1);
    @(negedge clk);
    drive(1, IDLE, '0, '0); s_sdata = 32'hD000_0008;
    #1; check_resp("c5", 32'hD000_0008);
`else
    @(negedge clk);
    drive(0, IDLE, '0, '0); drive(1, RD, 32'h1010, '0);
    #1; check_grant("c2", 1, 1'b1);
    @(negedge clk);
    drive(1, IDLE, '0, '0); drive(0, WRC, 32'h0014, 32'h77);
    #1; check_idle("c3_full");
    @(negedge clk);
    s_resp = DVA; s_sdata = 32'hD000_0007;
    #1; check_resp("c4", 32'hD000_0007); check_grant("c4", 0, 1'b1);
    @(negedge clk);
    drive(0, IDLE, '0, '0); s_sdata = 32'hD000_0008;
    #1; check_resp("c5", 32'hD000_0008);
`endif
    @(negedge clk);
    s_sdata = 32'hD000_0009;
    #1; check_resp("c6", 32'hD000_0009);

    // reset with two reads outstanding discards their tags
    @(negedge clk);
    s_resp = NULL; idle_all();
    drive(2, RD, 32'h2010, '0);
    #1; check_grant("d1", 2, 1'b1);
    @(negedge clk);
    drive(2, RD, 32'h2014, '0);
    #1; check_grant("d2", 2, 1'b1);
    @(negedge clk);
    reset = 1'b1; drive(2, IDLE, '0, '0); drive(1, RD, 32'h1014, '0);
    s_acc = 1'b0; s_resp = DVA; s_sdata = 32'hD000_000A;
    exp_q.delete();
    #1; check_idle("d3_rst"); check_resp("d3_rst", '0);
    @(negedge clk);
    #1; check_idle("d4_rst"); check_resp("d4_rst", '0); check("d4_state", dbg, ARB);
    @(negedge clk);
    reset = 1'b0; idle_all(); s_acc = 1'b1;
    #1; check_resp("d5_stray", 32'hD000_000A);
    @(negedge clk);
    s_resp = NULL;
    drive(0, RD, 32'h0020, '0); drive(1, RD, 32'h1020, '0);
    #1; check_grant("d6_rr0", 0, 1'b1);
    @(negedge clk);
    drive(0, IDLE, '0, '0);
    #1; check_grant("d7", 1, 1'b1);
    @(negedge clk);
    idle_all(); s_resp = DVA; s_sdata = 32'hD000_000B;
    #1; check_resp("d8", 32'hD000_000B);
    @(negedge clk);
    s_sdata = 32'hD000_000C;
    #1; check_resp("d9", 32'hD000_000C);
    @(negedge clk);
    s_resp = NULL;
    #1; check("drain", exp_q.size(), 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
